// File: rtl/instr_enc_if.sv
// Field-in / word-out bus of the MSP430 instruction encoder.
// The slave side belongs to instr_enc and the master side to whoever feeds it.
interface instr_enc_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  FORMAT;
    logic [3:0]  OPC;
    logic        BW;
    logic        Ad;
    logic [1:0]  As;
    logic [3:0]  reg_SA;
    logic [3:0]  reg_DA;
    logic [15:0] src_ext;
    logic [15:0] dst_ext;
    logic [9:0]  jmp_off;
    logic        load_addr;
    logic [15:0] addr_in;
    logic [15:0] MAB_out;
    logic [15:0] MDB_in;
    logic        word_valid;
    logic        word_ready;
    logic        done;
    logic        err;

    modport slave (
        input  in_valid, FORMAT, OPC, BW, Ad, As, reg_SA, reg_DA,
               src_ext, dst_ext, jmp_off, load_addr, addr_in, word_ready,
        output in_ready, MAB_out, MDB_in, word_valid, done, err
    );

    modport master (
        output in_valid, FORMAT, OPC, BW, Ad, As, reg_SA, reg_DA,
               src_ext, dst_ext, jmp_off, load_addr, addr_in, word_ready,
        input  in_ready, MAB_out, MDB_in, word_valid, done, err
    );
endinterface

// File: rtl/instr_enc.sv
// MSP430 instruction encoder: packs decoded fields into opcode plus extension words
// and emits them with addresses. Define CONST_GEN_EN to fold small immediates into R2/R3.
module instr_enc #(
    parameter logic [15:0] RESET_ADDR = 16'hC000
) (
    input logic        clk,
    input logic        rst_n,
    instr_enc_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EMIT_OP, EMIT_SRC, EMIT_DST} state_t;

    state_t      r_state;
    logic [15:0] r_addr;
    logic [15:0] r_word;
    logic [15:0] r_src;
    logic [15:0] r_dst;
    logic        r_need_src;
    logic        r_need_dst;
    logic        r_wvalid;
    logic        r_done;
    logic        r_err;

    logic        w_fmt1, w_fmt2, w_fmt12, w_illegal;
    logic [3:0]  w_sa;
    logic [1:0]  w_as;
    logic        w_need_src, w_need_dst;
    logic [15:0] w_op;
    logic [15:0] w_base;

    assign w_fmt1    = (bus.FORMAT == 2'd1);
    assign w_fmt2    = (bus.FORMAT == 2'd2);
    assign w_fmt12   = w_fmt1 | w_fmt2;
    assign w_illegal = (bus.FORMAT == 2'd0) || (w_fmt1 && bus.OPC < 4'd4) ||
                       (w_fmt2 && bus.OPC[2:0] == 3'd7);

    always_comb begin
        w_sa = bus.reg_SA;
        w_as = bus.As;
`ifdef CONST_GEN_EN
        // Immediates the constant generator can produce need no extension word
        if (w_fmt12 && bus.As == 2'b11 && bus.reg_SA == 4'd0) begin
            case (bus.src_ext)
                16'h0000: begin w_sa = 4'd3; w_as = 2'b00; end
                16'h0001: begin w_sa = 4'd3; w_as = 2'b01; end
                16'h0002: begin w_sa = 4'd3; w_as = 2'b10; end
                16'hFFFF: begin w_sa = 4'd3; w_as = 2'b11; end
                16'h0004: begin w_sa = 4'd2; w_as = 2'b10; end
                16'h0008: begin w_sa = 4'd2; w_as = 2'b11; end
                default:  begin w_sa = bus.reg_SA; w_as = bus.As; end
            endcase
        end
`endif
    end

    assign w_need_src = w_fmt12 && ((w_as == 2'b01 && w_sa != 4'd3) ||
                                    (w_as == 2'b11 && w_sa == 4'd0));
    assign w_need_dst = w_fmt1 && bus.Ad;

    always_comb begin
        case (bus.FORMAT)
            2'd1:    w_op = {bus.OPC, w_sa, bus.Ad, bus.BW, w_as, bus.reg_DA};
            2'd2:    w_op = {6'b000100, bus.OPC[2:0], bus.BW, w_as, w_sa};
            2'd3:    w_op = {3'b001, bus.OPC[2:0], bus.jmp_off};
            default: w_op = 16'h0000;
        endcase
    end

    // A same-cycle load wins, so the first word of the accepted instruction lands at addr_in
    assign w_base = bus.load_addr ? bus.addr_in : r_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_addr     <= RESET_ADDR;
            r_word     <= 16'h0000;
            r_src      <= 16'h0000;
            r_dst      <= 16'h0000;
            r_need_src <= 1'b0;
            r_need_dst <= 1'b0;
            r_wvalid   <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_addr <= w_base;
                    if (bus.in_valid) begin
                        if (w_illegal) begin
                            r_err <= 1'b1;
                        end else begin
                            r_word     <= w_op;
                            r_src      <= bus.src_ext;
                            r_dst      <= bus.dst_ext;
                            r_need_src <= w_need_src;
                            r_need_dst <= w_need_dst;
                            r_wvalid   <= 1'b1;
                            r_state    <= EMIT_OP;
                        end
                    end
                end
                EMIT_OP, EMIT_SRC, EMIT_DST: begin
                    if (bus.word_ready) begin
                        r_addr <= r_addr + 16'd2;
                        if (r_state == EMIT_OP && r_need_src) begin
                            r_word  <= r_src;
                            r_state <= EMIT_SRC;
                        end else if (r_state != EMIT_DST && r_need_dst) begin
                            r_word  <= r_dst;
                            r_state <= EMIT_DST;
                        end else begin
                            r_wvalid <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (r_state == IDLE);
    assign bus.MAB_out    = r_addr;
    assign bus.MDB_in     = r_word;
    assign bus.word_valid = r_wvalid;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
endmodule

// File: tb/tb_instr_enc.sv
// Self-checking bench for instr_enc: directed cases plus randomized field sets
// against an arithmetic reference of the MSP430 encoding rules.
module tb_instr_enc;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_enc_if bus();
    instr_enc dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [1:0]  fmt;
        logic [3:0]  opc;
        logic        bw;
        logic        ad;
        logic [1:0]  as_m;
        logic [3:0]  sa;
        logic [3:0]  da;
        logic [15:0] se;
        logic [15:0] de;
        logic [9:0]  jo;
    } fld_t;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];
    int exp_addr = 32'hC000;

    function automatic fld_t mk(int fmt, int opc, int bw, int ad, int as_m, int sa, int da,
                                int se, int de, int jo);
        fld_t f;
        f.fmt = 2'(fmt); f.opc = 4'(opc); f.bw = 1'(bw); f.ad = 1'(ad); f.as_m = 2'(as_m);
        f.sa = 4'(sa); f.da = 4'(da); f.se = 16'(se); f.de = 16'(de); f.jo = 10'(jo);
        return f;
    endfunction

    // Reference: word list from the encoding rules using place-value arithmetic
    task automatic model(input fld_t f, output bit ill);
        int sa, as_m, opc, w;
        exp_q.delete();
        opc = int'(f.opc);
        ill = (f.fmt == 0) || (f.fmt == 1 && opc < 4) || (f.fmt == 2 && opc % 8 == 7);
        if (ill) return;
        sa = int'(f.sa);
        as_m = int'(f.as_m);
`ifdef CONST_GEN_EN
        if (f.fmt != 3 && as_m == 3 && sa == 0) begin
            case (int'(f.se))
                0:      begin sa = 3; as_m = 0; end
                1:      begin sa = 3; as_m = 1; end
                2:      begin sa = 3; as_m = 2; end
                65535:  begin sa = 3; as_m = 3; end
                4:      begin sa = 2; as_m = 2; end
                8:      begin sa = 2; as_m = 3; end
                default: ;
            endcase
        end
`endif
        if (f.fmt == 1)
            w = opc * 4096 + sa * 256 + int'(f.ad) * 128 + int'(f.bw) * 64 + as_m * 16 + int'(f.da);
        else if (f.fmt == 2)
            w = 4096 + (opc % 8) * 128 + int'(f.bw) * 64 + as_m * 16 + sa;
        else
            w = 8192 + (opc % 8) * 1024 + int'(f.jo);
        exp_q.push_back(16'(w));
        if (f.fmt != 3 && ((as_m == 1 && sa != 3) || (as_m == 3 && sa == 0)))
            exp_q.push_back(f.se);
        if (f.fmt == 1 && f.ad)
            exp_q.push_back(f.de);
    endtask

    task automatic scramble_fields();
        bus.FORMAT = 2'($urandom); bus.OPC = 4'($urandom); bus.BW = 1'($urandom);
        bus.Ad = 1'($urandom); bus.As = 2'($urandom); bus.reg_SA = 4'($urandom);
        bus.reg_DA = 4'($urandom); bus.src_ext = 16'($urandom); bus.dst_ext = 16'($urandom);
        bus.jmp_off = 10'($urandom);
    endtask

    // bp: 0 = always ready, 1 = random ready (plus spurious loads), 2 = stall word 1 for 3 cycles
    task automatic run_instr(input string nm, input fld_t f, input int bp,
                             input bit do_load, input int la);
        bit ill;
        int cyc, popped, stall;
        model(f, ill);
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL %s in_ready_idle got=%b exp=1", nm, bus.in_ready);
        end
        bus.FORMAT = f.fmt; bus.OPC = f.opc; bus.BW = f.bw; bus.Ad = f.ad; bus.As = f.as_m;
        bus.reg_SA = f.sa; bus.reg_DA = f.da; bus.src_ext = f.se; bus.dst_ext = f.de;
        bus.jmp_off = f.jo; bus.in_valid = 1'b1;
        if (do_load) begin
            bus.load_addr = 1'b1; bus.addr_in = 16'(la); exp_addr = la;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.load_addr = 1'b0;
        scramble_fields();
        if (ill) begin
            @(negedge clk);
            checks++;
            if (bus.err !== 1'b1 || bus.word_valid !== 1'b0 || bus.MAB_out !== 16'(exp_addr)) begin
                failures++;
                $display("FAIL %s err_pulse got err=%b wv=%b mab=%h exp err=1 wv=0 mab=%h",
                         nm, bus.err, bus.word_valid, bus.MAB_out, 16'(exp_addr));
            end
            @(negedge clk);
            checks++;
            if (bus.err !== 1'b0 || bus.word_valid !== 1'b0) begin
                failures++;
                $display("FAIL %s err_one_cycle got err=%b wv=%b exp 0 0", nm, bus.err, bus.word_valid);
            end
            return;
        end
        cyc = 0; popped = 0; stall = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bp == 1) begin
                bus.word_ready = 1'($urandom);
                bus.load_addr = 1'($urandom);
                bus.addr_in = 16'($urandom);
            end else if (bp == 2 && popped == 1 && stall < 3) begin
                bus.word_ready = 1'b0;
                stall++;
            end else begin
                bus.word_ready = 1'b1;
            end
            checks++;
            if (bus.word_valid !== 1'b1 || bus.MAB_out !== 16'(exp_addr) ||
                bus.MDB_in !== exp_q[0] || bus.done !== 1'b0) begin
                failures++;
                $display("FAIL %s word%0d got wv=%b mab=%h mdb=%h done=%b exp wv=1 mab=%h mdb=%h done=0",
                         nm, popped, bus.word_valid, bus.MAB_out, bus.MDB_in, bus.done,
                         16'(exp_addr), exp_q[0]);
            end
            if (bus.word_ready) begin
                void'(exp_q.pop_front());
                popped++;
                exp_addr = (exp_addr + 2) % 65536;
            end
        end
        bus.load_addr = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL %s timeout words_left got=%0d exp=0", nm, exp_q.size());
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || bus.in_ready !== 1'b1 || bus.word_valid !== 1'b0 ||
            bus.MAB_out !== 16'(exp_addr)) begin
            failures++;
            $display("FAIL %s done got done=%b rdy=%b wv=%b mab=%h exp 1 1 0 mab=%h",
                     nm, bus.done, bus.in_ready, bus.word_valid, bus.MAB_out, 16'(exp_addr));
        end
        bus.word_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.load_addr = 1'b0; bus.addr_in = 16'h0; bus.word_ready = 1'b1;
        scramble_fields();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.MAB_out !== 16'hC000 || bus.MDB_in !== 16'h0 || bus.word_valid !== 1'b0 ||
            bus.done !== 1'b0 || bus.err !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset got mab=%h mdb=%h wv=%b done=%b err=%b rdy=%b exp C000 0000 0 0 0 1",
                     bus.MAB_out, bus.MDB_in, bus.word_valid, bus.done, bus.err, bus.in_ready);
        end
        rst_n = 1'b1;
        exp_addr = 32'hC000;
    endtask

    task automatic test_single_word();
        run_instr("mov_r4_r5", mk(1, 4, 0, 0, 0, 4, 5, 0, 0, 0), 0, 1, 32'hC000);
    endtask

    task automatic test_ext_words();
        run_instr("ext3", mk(1, 4, 0, 1, 3, 0, 2, 32'h1234, 32'h0200, 0), 0, 1, 32'hC000);
    endtask

    task automatic test_fmt_j_ii();
        run_instr("fmt_j", mk(3, 7, 0, 0, 0, 0, 0, 0, 0, 32'h3FF), 0, 0, 0);
        run_instr("fmt_ii", mk(2, 4, 0, 0, 0, 4, 0, 0, 0, 0), 0, 0, 0);
    endtask

    task automatic test_backpressure();
        run_instr("stall_src", mk(1, 4, 0, 1, 3, 0, 2, 32'h1234, 32'h0200, 0), 2, 1, 32'hC000);
    endtask

    task automatic test_illegal();
        run_instr("fmt0", mk(0, 4, 0, 0, 0, 4, 5, 0, 0, 0), 0, 0, 0);
        run_instr("fmt1_opc2", mk(1, 2, 0, 0, 0, 4, 5, 0, 0, 0), 0, 0, 0);
        run_instr("fmt2_opc7", mk(2, 7, 0, 0, 0, 4, 0, 0, 0, 0), 0, 0, 0);
    endtask

    task automatic test_const_gen();
        run_instr("mov_imm1", mk(1, 4, 0, 0, 3, 0, 5, 1, 0, 0), 0, 0, 0);
        run_instr("mov_imm8", mk(1, 4, 0, 0, 3, 0, 5, 8, 0, 0), 0, 0, 0);
        run_instr("push_immffff", mk(2, 4, 0, 0, 3, 0, 0, 32'hFFFF, 0, 0), 0, 0, 0);
    endtask

    task automatic test_wrap();
        run_instr("wrap", mk(1, 4, 0, 1, 0, 4, 6, 0, 32'h0010, 0), 0, 1, 32'hFFFE);
    endtask

    task automatic test_random();
        fld_t f;
        for (int i = 0; i < 40; i++) begin
            f = mk($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 1),
                   $urandom_range(0, 1), $urandom_range(0, 3),
                   ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15), $urandom_range(0, 15),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : $urandom_range(0, 65535),
                   $urandom_range(0, 65535), $urandom_range(0, 1023));
            run_instr($sformatf("rand%0d", i), f, 1, ($urandom_range(0, 3) == 0),
                      $urandom_range(0, 32767) * 2);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.FORMAT = 2'd1; bus.OPC = 4'd4; bus.Ad = 1'b1; bus.As = 2'b11; bus.reg_SA = 4'd0;
        bus.reg_DA = 4'd2; bus.src_ext = 16'h1234; bus.dst_ext = 16'h0200; bus.BW = 1'b0;
        bus.load_addr = 1'b1; bus.addr_in = 16'h8000; bus.in_valid = 1'b1; bus.word_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0; bus.load_addr = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.word_valid !== 1'b1 || bus.MAB_out !== 16'h8000) begin
            failures++;
            $display("FAIL mid_pre got wv=%b mab=%h exp 1 8000", bus.word_valid, bus.MAB_out);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.word_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.word_valid !== 1'b0 || bus.MAB_out !== 16'hC000 || bus.in_ready !== 1'b1 ||
            bus.done !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got wv=%b mab=%h rdy=%b done=%b exp 0 C000 1 0",
                     bus.word_valid, bus.MAB_out, bus.in_ready, bus.done);
        end
        exp_addr = 32'hC000;
        run_instr("after_reset", mk(2, 4, 0, 0, 0, 4, 0, 0, 0, 0), 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_ext_words();
        test_fmt_j_ii();
        test_backpressure();
        test_illegal();
        test_const_gen();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/instr_enc.md
Name: instr_enc

Overview:
- Instruction encoder/emitter: the write-side counterpart of the instruction decoder.
- Takes decoded MSP430 instruction fields (format, opcode, Ad/As, BW, registers, extension values) over a valid/ready handshake.
- Packs them into the 16-bit instruction word plus any extension words, and emits the words serially with a word address onto MAB/MDB-style outputs for a ROM/RAM loader or bench stimulus.

Parameters:
- RESET_ADDR, 16'hC000, address counter value after reset.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  instruction fields valid.
- in_ready  output  1  encoder can accept fields; high only in IDLE.
- FORMAT  input  2  1=FMT_I, 2=FMT_II, 3=FMT_J, 0=illegal.
- OPC  input  4  FMT_I: bits 15:12; FMT_II: OPC[2:0] → bits 9:7; FMT_J: OPC[2:0] = condition.
- BW  input  1  byte/word bit.
- Ad  input  1  destination mode (FMT_I only).
- As  input  2  source mode.
- reg_SA  input  4  source register (FMT_I) / operand register (FMT_II).
- reg_DA  input  4  destination register (FMT_I).
- src_ext  input  16  source extension value (index, absolute or immediate).
- dst_ext  input  16  destination extension value.
- jmp_off  input  10  signed jump word offset.
- load_addr  input  1  load addr_in into address counter.
- addr_in  input  16  new emit address.
- MAB_out  output  16  address of current word.
- MDB_in  output  16  current word.
- word_valid  output  1  MAB_out/MDB_in valid.
- word_ready  input  1  sink accepts word.
- done  output  1  one-cycle pulse after last word of an instruction is accepted.
- err  output  1  one-cycle pulse on illegal field set.

Behaviour:
- Reset (rst_n low at clk edge): state IDLE; MAB_out=RESET_ADDR; MDB_in=0; word_valid=0; done=0; err=0; in_ready=1 the cycle after.
- Accept on in_valid && in_ready. All fields are captured; later input changes are ignored until the next IDLE.
- Encoding:
  - FMT_I word = {OPC, reg_SA, Ad, BW, As, reg_DA}.
  - FMT_II word = {6'b000100, OPC[2:0], BW, As, reg_SA}.
  - FMT_J word = {3'b001, OPC[2:0], jmp_off}.
- Extension words:
  - src ext needed when (FMT_I or FMT_II) and ((As==01 && reg_SA!=3) or (As==11 && reg_SA==0)).
  - dst ext needed when FMT_I and Ad==1.
  - FMT_J never has extension words.
- Illegal fields: FORMAT==0, FMT_I with OPC<4, or FMT_II with OPC[2:0]==7. Result: err pulses the cycle after acceptance, no word emitted, state stays IDLE, address unchanged.
- FSM states: IDLE → EMIT_OP → (EMIT_SRC if needed) → (EMIT_DST if needed) → IDLE.
  - word_valid is high in all EMIT_* states.
  - Each state advances only on word_valid && word_ready.
- Latency: fields accepted at edge N; first word valid after edge N; a 3-word instruction with word_ready tied high takes 3 cycles.
- Backpressure: while word_valid && !word_ready, MAB_out and MDB_in hold stable and the state holds.
- Address counter:
  - Increments by 2 on each accepted word; wraps 16'hFFFE → 16'h0000.
  - load_addr is honoured only in IDLE and ignored elsewhere.
  - If load_addr and in_valid arrive in the same IDLE cycle, the load takes effect first, so the instruction's first word goes at addr_in.
- done: pulses the cycle after the final word handshake. in_ready reasserts the same cycle, so back-to-back instructions cost no gap.
- Reset mid-emission: partial instruction is abandoned, word_valid drops, address returns to RESET_ADDR.

Optional Feature:
- Macro: CONST_GEN_EN.
- When defined, immediate source (As==11, reg_SA==0) with src_ext in {0,1,2,4,8,FFFF} is re-encoded through the constant generator and no src ext word is emitted:
  - 0 → R3/As00
  - 1 → R3/As01
  - 2 → R3/As10
  - FFFF → R3/As11
  - 4 → R2/As10
  - 8 → R2/As11
- When undefined, immediates are always emitted as given, with an extension word.

Test Plan:
- load_addr 16'hC000; FMT_I OPC=4 SA=4 DA=5 Ad=0 As=00 → one word 16'h4405 at C000; done pulses; MAB_out then C002.
- FMT_I OPC=4 SA=0 As=11 Ad=1 DA=2 src_ext=1234 dst_ext=0200 → 40B2@C000, 1234@C002, 0200@C004.
- FMT_J OPC=7 jmp_off=3FF → 3FFF, single word. FMT_II OPC=4 SA=4 → 1204.
- Case 2 with word_ready low 3 cycles on the src word → MDB_in=1234 and MAB_out=C002 stable; resumes correctly.
- FORMAT=0, then FMT_I OPC=2 → err pulses each time, word_valid never high, address unchanged.
- MOV #1,R5 (OPC=4 SA=0 As=11 DA=5 src_ext=0001) → with CONST_GEN_EN: 4315 only; without: 4035, 0001. Also check address wrap at FFFE → 0000.
